aes_output_buffer: RTL and testbench

Output stage directly downstream of the AES decryption pipeline. It captures each finished 128-bit plaintext block when the pipeline flags completion, holds up to DEPTH blocks in a circular buffer, and streams them out as 32-bit words over a valid/ready handshake. It drives `is_full` back to the pipeline, which freezes all pipeline registers while it is high. No block may be lost or captured twice.

---
 rtl/aes_output_buffer_if.sv | 31 +++
 rtl/aes_output_buffer.sv | 79 +++++++
 tb/tb_aes_output_buffer.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_output_buffer_if.sv
// Handshake bundle between the AES pipeline, the output buffer and the word consumer.
// The master side is the buffer. It takes finished blocks in and drives the word stream out.
interface aes_output_buffer_if;
   logic         data_done;
   logic [127:0] data_output;
   logic         is_full;
   logic         word_valid;
   logic         word_ready;
   logic [31:0]  word_data;
   logic         block_last;

   modport master (
      input  data_done,
      input  data_output,
      input  word_ready,
      output is_full,
      output word_valid,
      output word_data,
      output block_last
   );

   modport slave (
      output data_done,
      output data_output,
      output word_ready,
      input  is_full,
      input  word_valid,
      input  word_data,
      input  block_last
   );
endinterface

// File: rtl/aes_output_buffer.sv
// Circular buffer of 128-bit plaintext blocks, streamed out as four 32-bit words per block.
// is_full comes only from the block count, so the pipeline freeze has no combinational path from inputs.
module aes_output_buffer #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     n_rst,
   input  logic                     clear,
   aes_output_buffer_if.master      bus,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [127:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [1:0]    widx;
   logic [CW-1:0] cnt;

   logic full;
   logic valid;
   logic push;
   logic fire;
   logic pop;

   // Word 0 is the most significant quarter of the block.
   function automatic logic [31:0] select_word(input logic [127:0] blk, input logic [1:0] idx);
      case (idx)
         2'd0:    return blk[127:96];
         2'd1:    return blk[95:64];
         2'd2:    return blk[63:32];
         default: return blk[31:0];
      endcase
   endfunction

   assign full  = (cnt == FULL_CNT);
   assign valid = (cnt != '0);
   assign push  = bus.data_done && !full;
   assign fire  = valid && bus.word_ready;
   assign pop   = fire && (widx == 2'd3);

   // Clear takes the same path as reset, so a push or pop in that cycle is discarded.
   always_ff @(posedge clk) begin
      if (!n_rst || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         widx   <= '0;
         cnt    <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (fire)
            widx <= widx + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Slot contents need no reset. A write into a slot that is not counted is harmless.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= bus.data_output;
   end

   assign bus.is_full    = full;
   assign bus.word_valid = valid;
   assign bus.word_data  = valid ? select_word(mem[rd_ptr], widx) : 32'h0;
   assign bus.block_last = valid && (widx == 2'd3);
   assign count          = cnt;

endmodule

// File: tb/tb_aes_output_buffer.sv
// Directed bench for aes_output_buffer. Inputs are driven and outputs are sampled on the falling edge.
module tb_aes_output_buffer;

   logic       clk = 1'b0;
   logic       n_rst;
   logic       clear;
   logic [2:0] count;
   int         checks = 0;
   int         failures = 0;
   logic [127:0] blk [0:9];

   always #5 clk = ~clk;

   aes_output_buffer_if bif();

   aes_output_buffer #(.DEPTH(4)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .clear (clear),
      .bus   (bif.master),
      .count (count)
   );

   function automatic logic [31:0] wsel(input logic [127:0] b, input int j);
      return b[127-32*j -: 32];
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      n_rst = 1'b0;
      tick();
      tick();
      checks++; if (bif.is_full !== 1'b0) begin failures++; $display("FAIL reset_is_full: got %b want 0", bif.is_full); end
      checks++; if (bif.word_valid !== 1'b0) begin failures++; $display("FAIL reset_word_valid: got %b want 0", bif.word_valid); end
      checks++; if (bif.block_last !== 1'b0) begin failures++; $display("FAIL reset_block_last: got %b want 0", bif.block_last); end
      checks++; if (bif.word_data !== 32'h0) begin failures++; $display("FAIL reset_word_data: got %h want 0", bif.word_data); end
      checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", count); end
      n_rst = 1'b1;
   endtask

   task automatic test_single_block();
      logic [31:0] exp_w [0:3];
      exp_w[0] = 32'h00112233; exp_w[1] = 32'h44556677;
      exp_w[2] = 32'h8899aabb; exp_w[3] = 32'hccddeeff;
      bif.word_ready  = 1'b1;
      bif.data_done   = 1'b1;
      bif.data_output = blk[0];
      checks++; if (bif.word_valid !== 1'b0) begin failures++; $display("FAIL single_no_bypass: got %b want 0", bif.word_valid); end
      tick();
      bif.data_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++; if (bif.word_valid !== 1'b1) begin failures++; $display("FAIL single_valid[%0d]: got %b want 1", i, bif.word_valid); end
         checks++; if (bif.word_data !== exp_w[i]) begin failures++; $display("FAIL single_word[%0d]: got %h want %h", i, bif.word_data, exp_w[i]); end
         checks++; if (bif.block_last !== (i == 3)) begin failures++; $display("FAIL single_last[%0d]: got %b want %b", i, bif.block_last, (i == 3)); end
         tick();
      end
      checks++; if (bif.word_valid !== 1'b0) begin failures++; $display("FAIL single_empty_valid: got %b want 0", bif.word_valid); end
      checks++; if (count !== 3'd0) begin failures++; $display("FAIL single_empty_count: got %0d want 0", count); end
   endtask

   task automatic test_fill_hold();
      logic [31:0] got [0:31];
      int words;
      int cyc;
      int first_free;
      bit push_now;
      bif.word_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         checks++; if (bif.is_full !== 1'b0) begin failures++; $display("FAIL fill_not_full[%0d]: got %b want 0", k, bif.is_full); end
         bif.data_done   = 1'b1;
         bif.data_output = blk[k];
         tick();
      end
      checks++; if (bif.is_full !== 1'b1) begin failures++; $display("FAIL fill_is_full: got %b want 1", bif.is_full); end
      checks++; if (count !== 3'd4) begin failures++; $display("FAIL fill_count: got %0d want 4", count); end
      bif.data_output = blk[4];
      for (int c = 0; c < 10; c++) begin
         tick();
         checks++; if (count !== 3'd4) begin failures++; $display("FAIL hold_count[%0d]: got %0d want 4", c, count); end
      end
      bif.word_ready = 1'b1;
      words = 0; cyc = 0; first_free = -1;
      while (words < 20 && cyc < 100) begin
         if (count > 3'd4) begin checks++; failures++; $display("FAIL hold_overflow: got %0d want <=4", count); end
         if (first_free < 0 && !bif.is_full) first_free = cyc;
         if (bif.word_valid && bif.word_ready) begin got[words] = bif.word_data; words++; end
         push_now = bif.data_done && !bif.is_full;
         tick();
         if (push_now) bif.data_done = 1'b0;
         cyc++;
      end
      checks++; if (words !== 20) begin failures++; $display("FAIL hold_word_total: got %0d want 20", words); end
      checks++; if (first_free !== 4) begin failures++; $display("FAIL hold_full_fall: got %0d want 4", first_free); end
      for (int i = 0; i < 20; i++) begin
         checks++; if (got[i] !== wsel(blk[i/4], i%4)) begin failures++; $display("FAIL hold_word[%0d]: got %h want %h", i, got[i], wsel(blk[i/4], i%4)); end
      end
      checks++; if (bif.word_valid !== 1'b0) begin failures++; $display("FAIL hold_drained_valid: got %b want 0", bif.word_valid); end
      checks++; if (count !== 3'd0) begin failures++; $display("FAIL hold_drained_count: got %0d want 0", count); end
      bif.data_done = 1'b0;
   endtask

   task automatic test_stall();
      logic [31:0] got [0:7];
      logic [31:0] prev_data;
      logic prev_valid;
      logic prev_ready;
      int words;
      int cyc;
      bif.word_ready  = 1'b0;
      bif.data_done   = 1'b1;
      bif.data_output = blk[5];
      tick();
      bif.data_done = 1'b0;
      words = 0; cyc = 0; prev_valid = 1'b0; prev_ready = 1'b0; prev_data = 32'h0;
      while (words < 4 && cyc < 40) begin
         bif.word_ready = cyc[0];
         if (prev_valid && !prev_ready) begin
            checks++; if (bif.word_data !== prev_data) begin failures++; $display("FAIL stall_stable[%0d]: got %h want %h", cyc, bif.word_data, prev_data); end
         end
         if (bif.word_valid && bif.word_ready) begin got[words] = bif.word_data; words++; end
         prev_valid = bif.word_valid;
         prev_ready = bif.word_ready;
         prev_data  = bif.word_data;
         tick();
         cyc++;
      end
      checks++; if (words !== 4) begin failures++; $display("FAIL stall_word_total: got %0d want 4", words); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (got[i] !== wsel(blk[5], i)) begin failures++; $display("FAIL stall_word[%0d]: got %h want %h", i, got[i], wsel(blk[5], i)); end
      end
      checks++; if (bif.word_valid !== 1'b0) begin failures++; $display("FAIL stall_drained: got %b want 0", bif.word_valid); end
      bif.word_ready = 1'b0;
   endtask

   task automatic test_wrap();
      logic [31:0] got [0:47];
      logic        last [0:47];
      int words;
      int pushed;
      int cyc;
      int last_cnt;
      bit push_now;
      words = 0; pushed = 0; cyc = 0; last_cnt = 0;
      while (words < 40 && cyc < 1000) begin
         bif.data_done   = (pushed < 10);
         bif.data_output = blk[pushed % 10];
         bif.word_ready  = 1'($urandom_range(0, 1));
         if (bif.word_valid && bif.word_ready) begin
            got[words] = bif.word_data;
            last[words] = bif.block_last;
            if (bif.block_last) last_cnt++;
            words++;
         end
         push_now = bif.data_done && !bif.is_full;
         tick();
         if (push_now) pushed++;
         cyc++;
      end
      bif.data_done  = 1'b0;
      bif.word_ready = 1'b0;
      checks++; if (words !== 40) begin failures++; $display("FAIL wrap_word_total: got %0d want 40", words); end
      checks++; if (last_cnt !== 10) begin failures++; $display("FAIL wrap_last_total: got %0d want 10", last_cnt); end
      for (int i = 0; i < 40; i++) begin
         checks++; if (got[i] !== wsel(blk[i/4], i%4) || last[i] !== (i%4 == 3)) begin
            failures++; $display("FAIL wrap_word[%0d]: got %h/%b want %h/%b", i, got[i], last[i], wsel(blk[i/4], i%4), (i%4 == 3));
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] got [0:7];
      int words;
      int cyc;
      bif.word_ready = 1'b0;
      bif.data_done = 1'b1; bif.data_output = blk[6]; tick();
      bif.data_output = blk[7]; tick();
      bif.data_done = 1'b0;
      checks++; if (count !== 3'd2) begin failures++; $display("FAIL b2b_pre_count: got %0d want 2", count); end
      bif.word_ready = 1'b1;
      tick(); tick(); tick();
      bif.data_done   = 1'b1;
      bif.data_output = blk[8];
      checks++; if (bif.block_last !== 1'b1 || bif.word_data !== wsel(blk[6], 3)) begin
         failures++; $display("FAIL b2b_last_word: got %h/%b want %h/1", bif.word_data, bif.block_last, wsel(blk[6], 3));
      end
      tick();
      bif.data_done  = 1'b0;
      bif.word_ready = 1'b0;
      checks++; if (count !== 3'd2) begin failures++; $display("FAIL b2b_count: got %0d want 2", count); end
      checks++; if (bif.word_data !== wsel(blk[7], 0) || bif.block_last !== 1'b0) begin
         failures++; $display("FAIL b2b_next_head: got %h/%b want %h/0", bif.word_data, bif.block_last, wsel(blk[7], 0));
      end
      bif.word_ready = 1'b1;
      words = 0; cyc = 0;
      while (words < 8 && cyc < 40) begin
         if (bif.word_valid) begin got[words] = bif.word_data; words++; end
         tick();
         cyc++;
      end
      bif.word_ready = 1'b0;
      checks++; if (words !== 8) begin failures++; $display("FAIL b2b_word_total: got %0d want 8", words); end
      for (int i = 0; i < 8; i++) begin
         checks++; if (got[i] !== wsel(blk[7 + i/4], i%4)) begin failures++; $display("FAIL b2b_word[%0d]: got %h want %h", i, got[i], wsel(blk[7 + i/4], i%4)); end
      end
   endtask

   task automatic test_flush_mid_block(input bit use_clear);
      string tag;
      tag = use_clear ? "clear" : "reset";
      bif.word_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         bif.data_done = 1'b1; bif.data_output = blk[k]; tick();
      end
      bif.data_done  = 1'b0;
      bif.word_ready = 1'b1;
      tick(); tick();
      bif.word_ready = 1'b0;
      checks++; if (bif.word_data !== wsel(blk[0], 2)) begin failures++; $display("FAIL %s_mid_word: got %h want %h", tag, bif.word_data, wsel(blk[0], 2)); end
      if (use_clear) clear = 1'b1; else n_rst = 1'b0;
      bif.data_done   = 1'b1;
      bif.data_output = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
      bif.word_ready  = 1'b1;
      tick();
      clear = 1'b0; n_rst = 1'b1;
      bif.data_done  = 1'b0;
      bif.word_ready = 1'b0;
      checks++; if (count !== 3'd0) begin failures++; $display("FAIL %s_count: got %0d want 0", tag, count); end
      checks++; if (bif.word_valid !== 1'b0) begin failures++; $display("FAIL %s_valid: got %b want 0", tag, bif.word_valid); end
      checks++; if (bif.is_full !== 1'b0) begin failures++; $display("FAIL %s_is_full: got %b want 0", tag, bif.is_full); end
      checks++; if (bif.word_data !== 32'h0) begin failures++; $display("FAIL %s_word_data: got %h want 0", tag, bif.word_data); end
      bif.data_done = 1'b1; bif.data_output = blk[9];
      tick();
      bif.data_done  = 1'b0;
      bif.word_ready = 1'b1;
      for (int j = 0; j < 4; j++) begin
         checks++; if (bif.word_data !== wsel(blk[9], j) || bif.block_last !== (j == 3)) begin
            failures++; $display("FAIL %s_restart[%0d]: got %h/%b want %h/%b", tag, j, bif.word_data, bif.block_last, wsel(blk[9], j), (j == 3));
         end
         tick();
      end
      bif.word_ready = 1'b0;
      checks++; if (bif.word_valid !== 1'b0) begin failures++; $display("FAIL %s_drained: got %b want 0", tag, bif.word_valid); end
   endtask

   initial begin
      blk[0] = 128'h00112233_44556677_8899aabb_ccddeeff;
      blk[1] = 128'h10000001_10000002_10000003_10000004;
      blk[2] = 128'h20000001_20000002_20000003_20000004;
      blk[3] = 128'h30000001_30000002_30000003_30000004;
      blk[4] = 128'h40000001_40000002_40000003_40000004;
      blk[5] = 128'h5a5a5a5a_a5a5a5a5_0f0f0f0f_f0f0f0f0;
      blk[6] = 128'h60000001_60000002_60000003_60000004;
      blk[7] = 128'h70000001_70000002_70000003_70000004;
      blk[8] = 128'h80000001_80000002_80000003_80000004;
      blk[9] = 128'h90000001_90000002_90000003_90000004;
      n_rst = 1'b0;
      clear = 1'b0;
      bif.data_done   = 1'b0;
      bif.data_output = '0;
      bif.word_ready  = 1'b0;
      @(negedge clk);
      test_reset();
      test_single_block();
      test_fill_hold();
      test_stall();
      test_wrap();
      test_back_to_back();
      test_flush_mid_block(1'b0);
      test_flush_mid_block(1'b1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
